// File: rtl/debug_slave_pkg.sv
// Shared definitions for the JTAG debug slave: IR action codes and default widths.
package debug_slave_pkg;

  localparam int unsigned DEFAULT_IR_WIDTH    = 2;
  localparam int unsigned DEFAULT_DATA_WIDTH  = 38;
  localparam int unsigned DEFAULT_CMD_DEPTH   = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  localparam logic [DEFAULT_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEFAULT_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEFAULT_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEFAULT_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/debug_slave_toggle_sync.sv
// Brings a TCK-domain toggle into clk and turns each toggle into a one-cycle event.
module debug_slave_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tgl_in,
  output logic event_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign event_out = sync_q[SYNC_STAGES-1] ^ edge_q;

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Sysclk-side command receiver: synchronises update-IR/DR events, queues {IR, DR}
// commands and hands them to the CPU debug logic with valid/ready plus an action pulse.
module debug_slave_cmd_queue
  import debug_slave_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = DEFAULT_IR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned CMD_DEPTH   = DEFAULT_CMD_DEPTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             uir_tgl,
  input  logic                             udr_tgl,
  input  logic [IR_WIDTH-1:0]              ir_in,
  input  logic [DATA_WIDTH-1:0]            sr,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [IR_WIDTH-1:0]              cmd_ir,
  output logic [DATA_WIDTH-1:0]            cmd_data,
  output logic [(2**IR_WIDTH)-1:0]         take_action,
  output logic [$clog2(CMD_DEPTH+1)-1:0]   fill_level,
  output logic                             overflow,
  input  logic                             ovf_clr
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned FW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned EW = IR_WIDTH + DATA_WIDTH;

  logic uir_evt, udr_evt;

  debug_slave_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .tgl_in   (uir_tgl),
    .event_out(uir_evt)
  );

  debug_slave_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .tgl_in   (udr_tgl),
    .event_out(udr_evt)
  );

  logic                uir_evt_q, uir_evt_d;
  logic                udr_evt_q, udr_evt_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [EW-1:0]       mem_q [CMD_DEPTH];

  logic                full, empty, push, pop, drop;
  logic [IR_WIDTH-1:0] ir_eff;
  logic [EW-1:0]       head;

  // Events are re-timed one stage before they touch the queue.
  always_comb begin
    uir_evt_d = uir_evt;
    udr_evt_d = udr_evt;
  end

  always_comb begin
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
             (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop    = !empty && cmd_ready;
    // A full queue still accepts a push when a pop frees the head slot.
    push   = udr_evt_q && (!full || pop);
    drop   = udr_evt_q && full && !pop;
    ir_eff = uir_evt_q ? ir_in : ir_q;

    ir_d       = uir_evt_q ? ir_in : ir_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_evt_q  <= 1'b0;
      udr_evt_q  <= 1'b0;
      ir_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      uir_evt_q  <= uir_evt_d;
      udr_evt_q  <= udr_evt_d;
      ir_q       <= ir_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally unreset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ir_eff, sr};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q[AW-1:0]];
    cmd_valid   = !empty;
    cmd_ir      = '0;
    cmd_data    = '0;
    take_action = '0;
    if (!empty) begin
      cmd_ir   = head[EW-1:DATA_WIDTH];
      cmd_data = head[DATA_WIDTH-1:0];
    end
    if (pop) take_action[cmd_ir] = 1'b1;
  end

  assign fill_level = FW'(wr_ptr_q - rd_ptr_q);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Directed self-checking bench for debug_slave_cmd_queue at default parameters.
module tb_debug_slave_cmd_queue;
  import debug_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        uir_tgl, udr_tgl;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  take_action;
  logic [2:0]  fill_level;
  logic        overflow, ovf_clr;

  int errors = 0;
  int checks = 0;

  debug_slave_cmd_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uir_tgl    (uir_tgl),
    .udr_tgl    (udr_tgl),
    .ir_in      (ir_in),
    .sr         (sr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_data   (cmd_data),
    .take_action(take_action),
    .fill_level (fill_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_ir(input logic [1:0] code);
    ir_in = code;
    @(negedge clk);
    uir_tgl = ~uir_tgl;
    wait_cycles(6);
  endtask

  task automatic send_dr(input logic [37:0] data);
    sr = data;
    @(negedge clk);
    udr_tgl = ~udr_tgl;
    wait_cycles(6);
  endtask

  task automatic pop_expect(input string tag, input logic [37:0] data);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({tag, "_data"}, 64'(cmd_data), 64'(data));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; uir_tgl = 1'b0; udr_tgl = 1'b0;
    ir_in = '0; sr = '0; cmd_ready = 1'b0; ovf_clr = 1'b0;

    // Reset held while the TCK side is busy
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      uir_tgl = ~uir_tgl; udr_tgl = ~udr_tgl; sr = 38'(i + 7); cmd_ready = 1'b1;
      #1;
      chk("rst_valid", 64'(cmd_valid), 64'd0);
      chk("rst_fill", 64'(fill_level), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_action", 64'(take_action), 64'd0);
    end
    @(negedge clk);
    uir_tgl = 1'b0; udr_tgl = 1'b0; cmd_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(6);
    chk("post_rst_valid", 64'(cmd_valid), 64'd0);
    chk("post_rst_fill", 64'(fill_level), 64'd0);
    chk("post_rst_ir", 64'(cmd_ir), 64'd0);
    chk("post_rst_data", 64'(cmd_data), 64'd0);

    // Single command with latency check
    set_ir(IR_BREAK);
    sr = 38'h2A_5A5A_5A5A;
    @(negedge clk);
    udr_tgl = ~udr_tgl;
    wait_cycles(3);
    chk("lat_edge2_valid", 64'(cmd_valid), 64'd0);
    @(negedge clk);
    chk("lat_edge3_valid", 64'(cmd_valid), 64'd1);
    chk("single_ir", 64'(cmd_ir), 64'd2);
    chk("single_data", 64'(cmd_data), 64'h2A_5A5A_5A5A);
    chk("single_fill", 64'(fill_level), 64'd1);
    cmd_ready = 1'b1;
    #1;
    chk("single_action", 64'(take_action), 64'b0100);
    @(negedge clk);
    chk("single_after_valid", 64'(cmd_valid), 64'd0);
    chk("single_after_action", 64'(take_action), 64'd0);
    cmd_ready = 1'b0;

    // Overflow: five commands into a four-entry queue
    for (int i = 1; i <= 5; i++) send_dr(38'(i));
    chk("ovf_fill", 64'(fill_level), 64'd4);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head_ir", 64'(cmd_ir), 64'd2);
    for (int i = 1; i <= 4; i++) pop_expect("ovf_pop", 38'(i));
    chk("ovf_drained_valid", 64'(cmd_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Full queue with a pop coinciding with the fifth push
    for (int i = 0; i < 4; i++) send_dr(38'(16 + i));
    chk("fullpop_fill_pre", 64'(fill_level), 64'd4);
    sr = 38'h14;
    @(negedge clk);
    udr_tgl = ~udr_tgl;
    wait_cycles(3);
    chk("fullpop_head_pre", 64'(cmd_data), 64'h10);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("fullpop_fill", 64'(fill_level), 64'd4);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    for (int i = 1; i <= 4; i++) pop_expect("fullpop_pop", 38'(16 + i));
    chk("fullpop_empty", 64'(cmd_valid), 64'd0);

    // uir and udr events in the same cycle: IR update applies first
    set_ir(IR_TRACEMEM);
    ir_in = IR_TRACECTRL;
    sr = 38'h3_0000_00C3;
    @(negedge clk);
    uir_tgl = ~uir_tgl; udr_tgl = ~udr_tgl;
    wait_cycles(6);
    chk("same_ir", 64'(cmd_ir), 64'd3);
    chk("same_data", 64'(cmd_data), 64'h3_0000_00C3);
    cmd_ready = 1'b1;
    #1;
    chk("same_action", 64'(take_action), 64'b1000);
    @(negedge clk);
    cmd_ready = 1'b0;

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) send_dr(38'(32 + i));
    chk("midrst_fill_pre", 64'(fill_level), 64'd3);
    @(negedge clk);
    reset_n = 1'b0; uir_tgl = 1'b0; udr_tgl = 1'b0;
    #1;
    chk("midrst_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_fill", 64'(fill_level), 64'd0);
    reset_n = 1'b1;
    wait_cycles(6);
    chk("midrst_no_spurious", 64'(fill_level), 64'd0);
    send_dr(38'h15_1234_5678);
    chk("midrst_next_valid", 64'(cmd_valid), 64'd1);
    chk("midrst_next_ir", 64'(cmd_ir), 64'd0);
    chk("midrst_next_data", 64'(cmd_data), 64'h15_1234_5678);
    chk("midrst_next_fill", 64'(fill_level), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_slave_cmd_queue.md
Name: debug_slave_cmd_queue

Overview:
System-clock-side command receiver for the JTAG debug slave, a parametrised successor to the fixed 2-bit-IR / 38-bit-DR sysclk decoder.
- Accepts toggle-encoded update-IR and update-DR events from the TCK-side shifter, plus the quasi-static IR and DR shift contents.
- Synchronises the events into clk and queues each completed {IR, DR} command in a small FIFO.
- Presents commands to the CPU debug logic with a valid/ready handshake, and emits a one-hot action pulse per IR code on consumption.

Parameters:
IR_WIDTH, 2, width of IR code; action vector width is 2**IR_WIDTH.
DATA_WIDTH, 38, width of the DR shift contents (jdo).
CMD_DEPTH, 4, FIFO entries; power of two, at least 2.
SYNC_STAGES, 2, synchroniser flops per toggle input; at least 2.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
uir_tgl  in  1  toggles once per update-IR in the TCK domain.
udr_tgl  in  1  toggles once per update-DR in the TCK domain.
ir_in  in  IR_WIDTH  IR contents; stable from before uir_tgl toggles until the next update-IR.
sr  in  DATA_WIDTH  DR contents; stable from before udr_tgl toggles until the next shift.
cmd_valid  out  1  FIFO head is valid.
cmd_ready  in  1  consumer accepts the head.
cmd_ir  out  IR_WIDTH  head IR code.
cmd_data  out  DATA_WIDTH  head DR data (jdo).
take_action  out  2**IR_WIDTH  one-hot pulse, bit = cmd_ir, on the pop cycle.
fill_level  out  clog2(CMD_DEPTH+1)  number of entries held.
overflow  out  1  sticky; a command was dropped while the FIFO was full.
ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, active-low): all synchroniser and edge flops, ir_q, pointers, fill_level and overflow go to 0. Outputs are then cmd_valid=0, take_action=0, cmd_ir=0, cmd_data=0. FIFO storage is not reset; cmd_ir and cmd_data are forced to 0 while cmd_valid=0.
- Sync: each toggle input passes through SYNC_STAGES flops, then one edge flop. The event is (last stage XOR edge flop), asserted for exactly 1 clk per input toggle.
- uir event: ir_q <= ir_in.
- udr event: push {ir_eff, sr}. ir_eff = ir_in if a uir event occurs in the same cycle, else ir_q. In other words, IR update is applied before the push.
- Latency: the first clk edge that samples a new udr_tgl value counts as edge 0. cmd_valid rises after edge SYNC_STAGES+1 (3 edges for the default). There is no bypass path.
- Pop: occurs when cmd_valid && cmd_ready. In the same cycle, take_action[cmd_ir] = 1 combinationally and all other bits are 0. The next entry appears on the following cycle.
- Full push: if fill_level == CMD_DEPTH with no pop in the same cycle, the command is dropped, the FIFO is unchanged, and overflow <= 1.
- Push and pop in the same cycle: both take effect and fill_level is unchanged, including when the FIFO is full. A full FIFO therefore accepts the push.
- Empty: cmd_ready is ignored and no pulse is generated.
- Overflow clear: ovf_clr clears overflow; if a drop occurs in the same cycle, the set wins.
- Pointers: read and write pointers are clog2(CMD_DEPTH)+1 bits and wrap modulo 2*CMD_DEPTH. full = MSBs differ and LSBs equal; empty = pointers equal.
- Multiple toggles: two toggles closer together than one clk may be lost. The TCK protocol guarantees at least 3 clk between udr toggles, so this is not handled.
- Reset mid-operation: queued commands are discarded. After release, the synchronisers initialise to 0. If uir_tgl or udr_tgl is 1 at release, one spurious event results. The TCK side resets its toggles from the same reset, so this is accepted.

Decomposition:
- Shared package debug_slave_pkg holds:
  - IR code constants: IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3.
  - Default widths.
- One sub-module, debug_slave_toggle_sync: parameter SYNC_STAGES; ports clk, reset_n, tgl_in, event_out. Instantiated twice.

Test Plan:
- Reset: hold reset_n=0 while toggles and sr are active → cmd_valid=0, fill_level=0, overflow=0, take_action=0 throughout; no events after release.
- Single command: ir_in=2, toggle uir_tgl, then sr=38'h2A_5A5A_5A5A, toggle udr_tgl → cmd_valid high exactly 3 edges after sampling; cmd_ir=2; cmd_data=38'h2A_5A5A_5A5A. Then cmd_ready=1 → take_action=4'b0100 for 1 cycle, cmd_valid=0 next cycle.
- Overflow: cmd_ready=0, send 5 commands with data 1..5 → fill_level=4, overflow=1; pops return 1,2,3,4; ovf_clr=1 → overflow=0.
- Full with simultaneous pop: fill to 4, hold cmd_ready=1 while a 5th udr event arrives → overflow stays 0, fill_level stays 4, order preserved, 5th entry popped last.
- Same-cycle events: uir and udr toggled together, ir_in=3 (ir_q=1) → queued cmd_ir=3.
- Reset mid-operation: 3 entries queued, pulse reset_n low for 1 ns → cmd_valid=0 immediately (asynchronous), fill_level=0; the next command is received normally.
